// File: rtl/cam_capture_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cam_capture_ctrl_pkg
// Shared definitions for the OV7670 frame-capture slice:
//   - state_t        : capture sequencer states
//   - IMG_*_DEF/AW_DEF: default frame geometry and buffer address width
//   - R/G/B_* slices : where the RGB332 fields come from in the two RGB565 bytes
//   - packRgb332     : folds the first (RRRRRGGG) and second (GGGBBBBB) byte
//                      into one {R[2:0],G[2:0],B[1:0]} pixel
// ---------------------------------------------------------------------------
package cam_capture_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_VS,
    ST_WAIT_ACT,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  localparam int IMG_W_DEF = 160;
  localparam int IMG_H_DEF = 120;
  localparam int AW_DEF    = 15;

  // Top three red bits and top three green bits live in the first byte,
  // top two blue bits sit at [4:3] of the second byte.
  localparam int R_HI = 7;
  localparam int R_LO = 5;
  localparam int G_HI = 2;
  localparam int G_LO = 0;
  localparam int B_HI = 4;
  localparam int B_LO = 3;

  function automatic logic [7:0] packRgb332(input logic [7:0] hiByte,
                                            input logic [7:0] loByte);
    return {hiByte[R_HI:R_LO], hiByte[G_HI:G_LO], loByte[B_HI:B_LO]};
  endfunction

endpackage

// File: rtl/cam_capture_ctrl_if.sv
// ---------------------------------------------------------------------------
// cam_capture_ctrl_if
// Bundles the camera-side inputs, the control handshake and the frame-buffer
// write port of the capture controller.
//   start            : one-cycle capture request
//   VSYNC/HREF/D     : camera frame sync, line valid, data byte
//   mem_addr/data/we : frame-buffer write port (RGB332 data)
//   busy/done        : capture in progress / end-of-capture pulse
//   line_err         : sticky short-line flag
// slave  = controller side, master = camera + host side.
// ---------------------------------------------------------------------------
interface cam_capture_ctrl_if #(
  parameter int AW = 15
);
  logic          start;
  logic          VSYNC;
  logic          HREF;
  logic [7:0]    D;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;
  logic          mem_we;
  logic          busy;
  logic          done;
  logic          line_err;

  modport slave (
    input  start, VSYNC, HREF, D,
    output mem_addr, mem_data, mem_we, busy, done, line_err
  );

  modport master (
    output start, VSYNC, HREF, D,
    input  mem_addr, mem_data, mem_we, busy, done, line_err
  );
endinterface

// File: rtl/cam_capture_ctrl_packer.sv
// ---------------------------------------------------------------------------
// rgb565_to_rgb332_packer
// Pairs camera bytes into pixels. Every enabled cycle with HREF high toggles
// the byte phase; the first byte is latched, and on the second byte the
// packed RGB332 pixel is presented combinationally with pixelValid_o so the
// controller can register it into the write port on the same edge.
//   clk_i, rst_i   : pixel clock, synchronous active-high reset
//   clear_i        : forces phase back to the first byte (line end / idle)
//   en_i           : packing enabled (controller is capturing)
//   href_i, d_i    : camera line valid and data byte
//   pixelValid_o   : second byte of a pair is on d_i this cycle
//   pixel_o        : packed {R[2:0],G[2:0],B[1:0]}
// ---------------------------------------------------------------------------
module rgb565_to_rgb332_packer
  import cam_capture_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic       href_i,
  input  logic [7:0] d_i,
  output logic       pixelValid_o,
  output logic [7:0] pixel_o
);

  logic       phase_q;
  logic [7:0] firstByte_q;

  // Byte phase and first-byte latch; clearing realigns pairing at each line.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      phase_q     <= 1'b0;
      firstByte_q <= 8'h00;
    end else if (en_i && href_i) begin
      if (!phase_q) begin
        firstByte_q <= d_i;
      end
      phase_q <= ~phase_q;
    end
  end

  assign pixelValid_o = en_i & href_i & phase_q;
  assign pixel_o      = packRgb332(firstByte_q, d_i);

endmodule

// File: rtl/cam_capture_ctrl.sv
// ---------------------------------------------------------------------------
// cam_capture_ctrl
// Frame-capture sequencer for an OV7670. A start pulse arms it; it then waits
// for a full VSYNC blanking interval (rise then fall) so capture always begins
// at a frame boundary, packs HREF-qualified byte pairs into RGB332 pixels and
// writes them to the frame buffer, IMG_W pixels per line, IMG_H lines.
//   PCLK : camera pixel clock, all logic on its rising edge
//   rst  : synchronous active-high reset
//   bus  : cam_capture_ctrl_if slave (camera inputs, start, write port,
//          busy/done/line_err status)
// ---------------------------------------------------------------------------
module cam_capture_ctrl
  import cam_capture_ctrl_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic               PCLK,
  input  logic               rst,
  cam_capture_ctrl_if.slave  bus
);

  localparam int XW = $clog2(IMG_W + 1);
  localparam int YW = $clog2(IMG_H + 1);
  localparam logic [XW-1:0] X_MAX  = XW'(IMG_W);
  localparam logic [YW-1:0] Y_MAX  = YW'(IMG_H);
  localparam logic [AW-1:0] LINE_W = AW'(IMG_W);

  state_t        state_q;
  logic          vsPrev_q;
  logic          hrefPrev_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [AW-1:0] wrPtr_q;
  logic [AW-1:0] lineBase_q;
  logic [AW-1:0] memAddr_q;
  logic [7:0]    memData_q;
  logic          memWe_q;
  logic          busy_q;
  logic          done_q;
  logic          lineErr_q;

  logic          vsRise;
  logic          vsFall;
  logic          hrefFall;
  logic          lineCounted;
  logic [YW-1:0] yNext_d;
  logic          frameFull;
  logic          capturing;
  logic          pixelValid;
  logic [7:0]    pixel;

  // Edge detection against the registered copies, plus the line/frame
  // accounting that decides whether this cycle ends the capture. A line that
  // ends together with a VSYNC rise is counted before the capture terminates.
  always_comb begin
    vsRise      = bus.VSYNC & ~vsPrev_q;
    vsFall      = ~bus.VSYNC & vsPrev_q;
    hrefFall    = hrefPrev_q & ~bus.HREF;
    lineCounted = hrefFall && (x_q != '0);
    yNext_d     = lineCounted ? (y_q + YW'(1)) : y_q;
    frameFull   = (yNext_d >= Y_MAX);
    capturing   = (state_q == ST_CAPTURE);
  end

  rgb565_to_rgb332_packer u_packer (
    .clk_i        (PCLK),
    .rst_i        (rst),
    .clear_i      (~capturing | hrefFall),
    .en_i         (capturing),
    .href_i       (bus.HREF),
    .d_i          (bus.D),
    .pixelValid_o (pixelValid),
    .pixel_o      (pixel)
  );

  // Capture sequencer. The write strobe and done are single-cycle by default;
  // a write issued in the last CAPTURE cycle still appears during DONE.
  // Pixels past IMG_W hold x at IMG_W and are dropped. Each counted line
  // realigns the pointer to the next line base so short lines leave gaps.
  always_ff @(posedge PCLK) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      vsPrev_q   <= 1'b0;
      hrefPrev_q <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      wrPtr_q    <= '0;
      lineBase_q <= '0;
      memAddr_q  <= '0;
      memData_q  <= 8'h00;
      memWe_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      lineErr_q  <= 1'b0;
    end else begin
      vsPrev_q   <= bus.VSYNC;
      hrefPrev_q <= bus.HREF;
      memWe_q    <= 1'b0;
      done_q     <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            busy_q    <= 1'b1;
            lineErr_q <= 1'b0;
            state_q   <= ST_WAIT_VS;
          end
        end

        ST_WAIT_VS: begin
          if (vsRise) begin
            state_q <= ST_WAIT_ACT;
          end
        end

        ST_WAIT_ACT: begin
          if (vsFall) begin
            x_q        <= '0;
            y_q        <= '0;
            wrPtr_q    <= '0;
            lineBase_q <= '0;
            memAddr_q  <= '0;
            state_q    <= ST_CAPTURE;
          end
        end

        ST_CAPTURE: begin
          if (pixelValid && (x_q < X_MAX)) begin
            x_q <= x_q + XW'(1);
            if (y_q < Y_MAX) begin
              memWe_q   <= 1'b1;
              memData_q <= pixel;
              memAddr_q <= wrPtr_q;
              wrPtr_q   <= wrPtr_q + AW'(1);
            end
          end
          if (hrefFall) begin
            x_q <= '0;
            if (lineCounted) begin
              y_q        <= yNext_d;
              lineBase_q <= lineBase_q + LINE_W;
              wrPtr_q    <= lineBase_q + LINE_W;
              if (x_q < X_MAX) begin
                lineErr_q <= 1'b1;
              end
            end
          end
          if (frameFull || vsRise) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_DONE;
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_addr = memAddr_q;
  assign bus.mem_data = memData_q;
  assign bus.mem_we   = memWe_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.line_err = lineErr_q;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cam_capture_ctrl
// Directed bench for cam_capture_ctrl with a 4x2 frame geometry. A monitor
// logs every frame-buffer write and done pulse; scenario tasks drive camera
// timing and compare against hand-computed addresses and RGB332 values.
// ---------------------------------------------------------------------------
module tb_cam_capture_ctrl;

  logic PCLK;
  logic rst;

  cam_capture_ctrl_if #(.AW(15)) bus ();

  cam_capture_ctrl #(
    .IMG_W (4),
    .IMG_H (2),
    .AW    (15)
  ) dut (
    .PCLK (PCLK),
    .rst  (rst),
    .bus  (bus)
  );

  int checks;
  int errors;

  logic [14:0] wrAddr[$];
  logic [7:0]  wrData[$];
  int          doneCount;
  int          doneWhileBusy;

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Log writes and done pulses mid-cycle, away from the rising edge.
  always @(negedge PCLK) begin
    if (bus.mem_we === 1'b1) begin
      wrAddr.push_back(bus.mem_addr);
      wrData.push_back(bus.mem_data);
    end
    if (bus.done === 1'b1) begin
      doneCount++;
      if (bus.busy !== 1'b0) doneWhileBusy++;
    end
  end

  // One camera cycle: apply values, let the DUT sample them, return just after.
  task automatic drive(input logic vs, input logic hr, input logic [7:0] d);
    bus.VSYNC = vs;
    bus.HREF  = hr;
    bus.D     = d;
    @(posedge PCLK);
    #1;
  endtask

  task automatic pulseStart();
    bus.start = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
    bus.start = 1'b0;
  endtask

  task automatic vsyncPulse();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic sendLine(input int nPix, input logic [7:0] b0, input logic [7:0] b1);
    for (int i = 0; i < nPix; i++) begin
      drive(1'b0, 1'b1, b0);
      drive(1'b0, 1'b1, b1);
    end
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic clearLogs();
    wrAddr.delete();
    wrData.delete();
    doneCount     = 0;
    doneWhileBusy = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    checks++;
    if ({bus.mem_we, bus.busy, bus.done, bus.line_err} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags got we/busy/done/err=%b expected 0000",
               {bus.mem_we, bus.busy, bus.done, bus.line_err});
    end
    checks++;
    if (bus.mem_addr !== 15'd0 || bus.mem_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_port got addr=%0d data=%h expected 0/00", bus.mem_addr, bus.mem_data);
    end
    clearLogs();
    vsyncPulse();
    sendLine(4, 8'hF8, 8'h1F);
    sendLine(4, 8'hF8, 8'h1F);
    vsyncPulse();
    checks++;
    if (wrAddr.size() != 0 || doneCount != 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_frame got writes=%0d done=%0d busy=%b expected 0/0/0",
               wrAddr.size(), doneCount, bus.busy);
    end
  endtask

  task automatic test_nominal();
    clearLogs();
    pulseStart();
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL start_busy got %b expected 1", bus.busy);
    end
    vsyncPulse();
    drive(1'b0, 1'b1, 8'hF8);
    drive(1'b0, 1'b1, 8'h1F);
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 15'd0 || bus.mem_data !== 8'hE3) begin
      errors++;
      $display("[TB] FAIL write_latency got we=%b addr=%0d data=%h expected 1/0/e3",
               bus.mem_we, bus.mem_addr, bus.mem_data);
    end
    sendLine(3, 8'hF8, 8'h1F);
    sendLine(4, 8'hF8, 8'h1F);
    checks++;
    if (wrAddr.size() != 8) begin
      errors++;
      $display("[TB] FAIL nominal_count got %0d expected 8", wrAddr.size());
    end
    for (int i = 0; i < wrAddr.size(); i++) begin
      checks++;
      if (wrAddr[i] !== 15'(i) || wrData[i] !== 8'hE3) begin
        errors++;
        $display("[TB] FAIL nominal_write[%0d] got addr=%0d data=%h expected %0d/e3",
                 i, wrAddr[i], wrData[i], i);
      end
    end
    checks++;
    if (doneCount != 1 || doneWhileBusy != 0 || bus.busy !== 1'b0 || bus.line_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL nominal_done got done=%0d overlap=%0d busy=%b err=%b expected 1/0/0/0",
               doneCount, doneWhileBusy, bus.busy, bus.line_err);
    end
  endtask

  task automatic test_long_line();
    clearLogs();
    pulseStart();
    vsyncPulse();
    sendLine(6, 8'hF8, 8'h1F);
    sendLine(4, 8'h5A, 8'hC8);
    checks++;
    if (wrAddr.size() != 8) begin
      errors++;
      $display("[TB] FAIL long_count got %0d expected 8", wrAddr.size());
    end
    for (int i = 0; i < wrAddr.size(); i++) begin
      checks++;
      if (wrAddr[i] !== 15'(i) || wrData[i] !== ((i < 4) ? 8'hE3 : 8'h49)) begin
        errors++;
        $display("[TB] FAIL long_write[%0d] got addr=%0d data=%h expected %0d/%h",
                 i, wrAddr[i], wrData[i], i, ((i < 4) ? 8'hE3 : 8'h49));
      end
    end
    checks++;
    if (bus.line_err !== 1'b0 || doneCount != 1) begin
      errors++;
      $display("[TB] FAIL long_status got err=%b done=%0d expected 0/1", bus.line_err, doneCount);
    end
  endtask

  task automatic test_short_line();
    logic [14:0] expAddr[7];
    expAddr = '{15'd0, 15'd1, 15'd2, 15'd4, 15'd5, 15'd6, 15'd7};
    clearLogs();
    pulseStart();
    vsyncPulse();
    sendLine(3, 8'hF8, 8'h1F);
    checks++;
    if (bus.line_err !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL short_flag got err=%b busy=%b expected 1/1", bus.line_err, bus.busy);
    end
    sendLine(4, 8'hF8, 8'h1F);
    checks++;
    if (wrAddr.size() != 7) begin
      errors++;
      $display("[TB] FAIL short_count got %0d expected 7", wrAddr.size());
    end
    for (int i = 0; i < wrAddr.size() && i < 7; i++) begin
      checks++;
      if (wrAddr[i] !== expAddr[i]) begin
        errors++;
        $display("[TB] FAIL short_addr[%0d] got %0d expected %0d", i, wrAddr[i], expAddr[i]);
      end
    end
    checks++;
    if (bus.line_err !== 1'b1 || doneCount != 1) begin
      errors++;
      $display("[TB] FAIL short_sticky got err=%b done=%0d expected 1/1", bus.line_err, doneCount);
    end
  endtask

  task automatic test_mid_frame_start();
    clearLogs();
    drive(1'b0, 1'b1, 8'h07);
    bus.start = 1'b1;
    drive(1'b0, 1'b1, 8'hE0);
    bus.start = 1'b0;
    checks++;
    if (bus.line_err !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_start got err=%b busy=%b expected 0/1", bus.line_err, bus.busy);
    end
    sendLine(4, 8'h07, 8'hE0);
    sendLine(4, 8'h07, 8'hE0);
    checks++;
    if (wrAddr.size() != 0) begin
      errors++;
      $display("[TB] FAIL mid_nowrite got %0d writes expected 0", wrAddr.size());
    end
    vsyncPulse();
    sendLine(4, 8'h07, 8'hE0);
    sendLine(4, 8'h07, 8'hE0);
    checks++;
    if (wrAddr.size() != 8 || doneCount != 1) begin
      errors++;
      $display("[TB] FAIL mid_frame got writes=%0d done=%0d expected 8/1", wrAddr.size(), doneCount);
    end
    for (int i = 0; i < wrAddr.size(); i++) begin
      checks++;
      if (wrAddr[i] !== 15'(i) || wrData[i] !== 8'h1C) begin
        errors++;
        $display("[TB] FAIL mid_write[%0d] got addr=%0d data=%h expected %0d/1c",
                 i, wrAddr[i], wrData[i], i);
      end
    end
  endtask

  task automatic test_reset_mid_capture();
    clearLogs();
    pulseStart();
    vsyncPulse();
    sendLine(4, 8'hF8, 8'h1F);
    drive(1'b0, 1'b1, 8'hF8);
    drive(1'b0, 1'b1, 8'h1F);
    rst = 1'b1;
    drive(1'b0, 1'b1, 8'hF8);
    rst = 1'b0;
    checks++;
    if (wrAddr.size() != 5 || bus.mem_we !== 1'b0 || bus.busy !== 1'b0 || bus.mem_addr !== 15'd0) begin
      errors++;
      $display("[TB] FAIL rst_mid got writes=%0d we=%b busy=%b addr=%0d expected 5/0/0/0",
               wrAddr.size(), bus.mem_we, bus.busy, bus.mem_addr);
    end
    drive(1'b0, 1'b1, 8'h1F);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'h00);
    clearLogs();
    pulseStart();
    vsyncPulse();
    drive(1'b0, 1'b1, 8'hF8);
    bus.start = 1'b1;
    drive(1'b0, 1'b1, 8'h1F);
    bus.start = 1'b0;
    sendLine(3, 8'hF8, 8'h1F);
    sendLine(4, 8'hF8, 8'h1F);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 8'h00);
    checks++;
    if (wrAddr.size() != 8 || doneCount != 1 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_recapture got writes=%0d done=%0d busy=%b expected 8/1/0",
               wrAddr.size(), doneCount, bus.busy);
    end
    for (int i = 0; i < wrAddr.size(); i++) begin
      checks++;
      if (wrAddr[i] !== 15'(i)) begin
        errors++;
        $display("[TB] FAIL rst_addr[%0d] got %0d expected %0d", i, wrAddr[i], i);
      end
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    doneCount     = 0;
    doneWhileBusy = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.VSYNC     = 1'b0;
    bus.HREF      = 1'b0;
    bus.D         = 8'h00;
    @(posedge PCLK);
    #1;
    test_reset();
    test_nominal();
    test_long_line();
    test_short_line();
    test_mid_frame_start();
    test_reset_mid_capture();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
